vscale_htif_tohost_monitor: RTL and testbench

- Host-side HTIF PCR master that sits directly upstream of vscale_sim_top's htif_pcr_req_*/htif_pcr_resp_* interface. Replaces constant tie-offs.
- Polls the tohost CSR with PCR reads until the core writes a non-zero value, then clears tohost with a PCR write.
- Reports pass, fail code or timeout to the simulation top.

---
 rtl/vscale_htif_tohost_monitor_if.sv | 50 +++++
 rtl/vscale_htif_tohost_monitor.sv | 198 +++++++++++++++++++
 tb/tb_vscale_htif_tohost_monitor.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vscale_htif_tohost_monitor_if.sv
// ---------------------------------------------------------------------------
// vscale_htif_tohost_monitor_if
//
// HTIF PCR request/response channel between a host-side PCR master (the
// tohost monitor) and the vscale simulation top (the PCR slave).
//
// Signals:
//   htif_pcr_req_valid   master -> slave  request valid
//   htif_pcr_req_ready   slave  -> master request accepted
//   htif_pcr_req_rw      master -> slave  1 = write, 0 = read
//   htif_pcr_req_addr    master -> slave  12-bit CSR address
//   htif_pcr_req_data    master -> slave  write data
//   htif_pcr_resp_valid  slave  -> master response valid
//   htif_pcr_resp_ready  master -> slave  response accepted
//   htif_pcr_resp_data   slave  -> master response data
// ---------------------------------------------------------------------------
interface vscale_htif_tohost_monitor_if #(
    parameter int HTIF_PCR_WIDTH = 64
) ();
    logic                      htif_pcr_req_valid;
    logic                      htif_pcr_req_ready;
    logic                      htif_pcr_req_rw;
    logic [11:0]               htif_pcr_req_addr;
    logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data;
    logic                      htif_pcr_resp_valid;
    logic                      htif_pcr_resp_ready;
    logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data;

    modport master (
        output htif_pcr_req_valid,
        output htif_pcr_req_rw,
        output htif_pcr_req_addr,
        output htif_pcr_req_data,
        output htif_pcr_resp_ready,
        input  htif_pcr_req_ready,
        input  htif_pcr_resp_valid,
        input  htif_pcr_resp_data
    );

    modport slave (
        input  htif_pcr_req_valid,
        input  htif_pcr_req_rw,
        input  htif_pcr_req_addr,
        input  htif_pcr_req_data,
        input  htif_pcr_resp_ready,
        output htif_pcr_req_ready,
        output htif_pcr_resp_valid,
        output htif_pcr_resp_data
    );
endinterface

// File: rtl/vscale_htif_tohost_monitor.sv
// ---------------------------------------------------------------------------
// vscale_htif_tohost_monitor
//
// Host-side HTIF PCR master. Polls the tohost CSR with PCR reads until the
// core writes a non-zero value, clears tohost with a PCR write, then reports
// pass (tohost == 1), fail (fail_code = tohost >> 1) or timeout.
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-low reset
//   max_cycles   timeout limit in cycles, 0 disables the timeout
//   pcr          HTIF PCR request/response channel (master side)
//   done         sticky, test finished
//   pass         sticky, tohost == 1
//   fail         sticky, tohost non-zero and != 1
//   timeout      sticky, cycle limit exceeded
//   fail_code    tohost >> 1 on fail, else 0
//   cycle_count  cycles since reset release, frozen once done
//
// All outputs are registered; request/response handshake outputs are computed
// from the next state so they line up with the state register.
// ---------------------------------------------------------------------------
module vscale_htif_tohost_monitor #(
    parameter int          HTIF_PCR_WIDTH = 64,
    parameter logic [11:0] TOHOST_ADDR    = 12'h780,
    parameter int          POLL_GAP       = 8,
    parameter int          CNT_W          = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CNT_W-1:0]            max_cycles,
    vscale_htif_tohost_monitor_if.master pcr,
    output logic                        done,
    output logic                        pass,
    output logic                        fail,
    output logic                        timeout,
    output logic [HTIF_PCR_WIDTH-1:0]   fail_code,
    output logic [CNT_W-1:0]            cycle_count
);

    // Gap counter holds at most POLL_GAP-1.
    localparam int GAP_W = (POLL_GAP > 2) ? $clog2(POLL_GAP) : 1;

    typedef enum logic [2:0] {
        RD_REQ,
        RD_RESP,
        GAP,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [GAP_W-1:0]          gap_q, gap_d;
    logic [HTIF_PCR_WIDTH-1:0] tohost_q, tohost_d;
    logic                      req_valid_q, req_valid_d;
    logic                      req_rw_q, req_rw_d;
    logic                      resp_ready_q, resp_ready_d;
    logic                      done_q, done_d;
    logic                      pass_q, pass_d;
    logic                      fail_q, fail_d;
    logic                      timeout_q, timeout_d;
    logic [HTIF_PCR_WIDTH-1:0] fail_code_q, fail_code_d;
    logic [CNT_W-1:0]          cycle_count_q, cycle_count_d;

    logic req_fire;
    logic resp_fire;
    logic timeout_hit;

    always_comb begin
        state_d       = state_q;
        gap_d         = gap_q;
        tohost_d      = tohost_q;
        done_d        = done_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        timeout_d     = timeout_q;
        fail_code_d   = fail_code_q;
        cycle_count_d = cycle_count_q;

        req_fire    = req_valid_q && pcr.htif_pcr_req_ready;
        resp_fire   = resp_ready_q && pcr.htif_pcr_resp_valid;
        timeout_hit = (max_cycles != '0) && (cycle_count_q > max_cycles) && !done_q;

        // Saturating counter, frozen once done.
        if (!done_q && (cycle_count_q != '1)) begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
        end

        case (state_q)
            RD_REQ: begin
                if (req_fire) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (resp_fire) begin
                    if (pcr.htif_pcr_resp_data == '0) begin
                        // Re-request lands POLL_GAP cycles after the zero response.
                        if (POLL_GAP == 1) begin
                            state_d = RD_REQ;
                        end else begin
                            state_d = GAP;
                            gap_d   = GAP_W'(POLL_GAP - 1);
                        end
                    end else begin
                        tohost_d = pcr.htif_pcr_resp_data;
                        state_d  = WR_REQ;
                    end
                end
            end
            GAP: begin
                // Leave one cycle early so the registered req_valid rises on time.
                if (gap_q <= GAP_W'(1)) begin
                    state_d = RD_REQ;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            WR_REQ: begin
                if (req_fire) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (resp_fire) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (tohost_q == HTIF_PCR_WIDTH'(1)) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_d      = 1'b1;
                        fail_code_d = tohost_q >> 1;
                    end
                end
            end
            DONE:    state_d = DONE;
            default: state_d = RD_REQ;
        endcase

        // A completed clearing write beats a simultaneous timeout; anything
        // else in flight is abandoned.
        if (timeout_hit && !((state_q == WR_RESP) && resp_fire)) begin
            state_d   = DONE;
            done_d    = 1'b1;
            timeout_d = 1'b1;
        end

        req_valid_d  = (state_d == RD_REQ) || (state_d == WR_REQ);
        req_rw_d     = (state_d == WR_REQ);
        resp_ready_d = (state_d == RD_RESP) || (state_d == WR_RESP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RD_REQ;
            gap_q         <= '0;
            tohost_q      <= '0;
            req_valid_q   <= 1'b0;
            req_rw_q      <= 1'b0;
            resp_ready_q  <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            fail_code_q   <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            gap_q         <= gap_d;
            tohost_q      <= tohost_d;
            req_valid_q   <= req_valid_d;
            req_rw_q      <= req_rw_d;
            resp_ready_q  <= resp_ready_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
            fail_code_q   <= fail_code_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign pcr.htif_pcr_req_valid  = req_valid_q;
    assign pcr.htif_pcr_req_rw     = req_rw_q;
    assign pcr.htif_pcr_req_addr   = TOHOST_ADDR;
    assign pcr.htif_pcr_req_data   = '0;
    assign pcr.htif_pcr_resp_ready = resp_ready_q;

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign fail_code   = fail_code_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_vscale_htif_tohost_monitor.sv
// ---------------------------------------------------------------------------
// tb_vscale_htif_tohost_monitor
//
// Acts as the HTIF PCR slave with randomized ready/response timing and holds
// a transaction-level model of the monitor: which cycle a request is due,
// whether a transfer is outstanding, the polled value sequence and the
// timeout rule. Every cycle the DUT outputs are compared with the model.
// ---------------------------------------------------------------------------
module tb_vscale_htif_tohost_monitor;

    localparam int          W    = 64;
    localparam int          CW   = 64;
    localparam int          PG   = 8;
    localparam logic [11:0] ADDR = 12'h780;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [CW-1:0] max_cycles = '0;
    logic          done, pass, fail, timeout;
    logic [W-1:0]  fail_code;
    logic [CW-1:0] cycle_count;

    int nvec = 0;
    int nerr = 0;

    vscale_htif_tohost_monitor_if #(.HTIF_PCR_WIDTH(W)) pcr ();

    vscale_htif_tohost_monitor #(
        .HTIF_PCR_WIDTH (W),
        .TOHOST_ADDR    (ADDR),
        .POLL_GAP       (PG),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .max_cycles  (max_cycles),
        .pcr         (pcr),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .fail_code   (fail_code),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".req_valid"},  pcr.htif_pcr_req_valid, 0);
        chk({tag, ".req_rw"},     pcr.htif_pcr_req_rw, 0);
        chk({tag, ".req_addr"},   pcr.htif_pcr_req_addr, 64'h780);
        chk({tag, ".req_data"},   pcr.htif_pcr_req_data, 0);
        chk({tag, ".resp_ready"}, pcr.htif_pcr_resp_ready, 0);
        chk({tag, ".done"},       done, 0);
        chk({tag, ".pass"},       pass, 0);
        chk({tag, ".fail"},       fail, 0);
        chk({tag, ".timeout"},    timeout, 0);
        chk({tag, ".fail_code"},  fail_code, 0);
        chk({tag, ".cycle_count"}, cycle_count, 0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        pcr.htif_pcr_req_ready  = 1'b0;
        pcr.htif_pcr_resp_valid = 1'b0;
        pcr.htif_pcr_resp_data  = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
    endtask

    // Releases reset at a negedge and runs one test to completion.
    // n_zero zero reads precede final_val. stall: ready forced low through
    // that cycle. rst_in_wr: hold off the clearing write and reset the DUT.
    task automatic run_scenario(input int n_zero, input logic [63:0] final_val,
                                input logic [63:0] maxc, input int rdy_pct,
                                input int stall, input int dmin, input int dmax,
                                input bit rst_in_wr, input int budget);
        logic [63:0] m_cyc;
        logic [63:0] m_code;
        logic [63:0] latched;
        bit          m_done, m_pass, m_fail, m_to;
        bit          outst, wr_phase, wr_sent, cur_wr, reset_hit;
        int          next_req, reads_done, rsp_at, settle, wr_wait;

        m_cyc = '0; m_code = '0; latched = '0;
        m_done = 0; m_pass = 0; m_fail = 0; m_to = 0;
        outst = 0; wr_phase = 0; wr_sent = 0; cur_wr = 0; reset_hit = 0;
        next_req = 1; reads_done = 0; rsp_at = 0; settle = 0; wr_wait = 0;
        max_cycles = maxc;
        reset = 1'b1;

        for (int n = 0; n < budget; n++) begin
            bit          exp_rv, exp_rr, xfer, acc, to_c, rdy, rv;
            logic [63:0] rd;

            exp_rv = !m_done && !outst && !wr_sent && (n >= next_req);
            exp_rr = !m_done && outst;

            chk("req_valid",  pcr.htif_pcr_req_valid, exp_rv);
            if (exp_rv) chk("req_rw", pcr.htif_pcr_req_rw, wr_phase);
            chk("req_addr",   pcr.htif_pcr_req_addr, 64'h780);
            chk("req_data",   pcr.htif_pcr_req_data, 0);
            chk("resp_ready", pcr.htif_pcr_resp_ready, exp_rr);
            chk("done",       done, m_done);
            chk("pass",       pass, m_pass);
            chk("fail",       fail, m_fail);
            chk("timeout",    timeout, m_to);
            chk("fail_code",  fail_code, m_code);
            chk("cycle_count", cycle_count, m_cyc);

            if (m_done) begin
                settle++;
                if (settle > 4) break;
            end

            if (rst_in_wr && exp_rv && wr_phase) begin
                wr_wait++;
                if (wr_wait == 3) begin
                    #2 reset = 1'b0;
                    #1 check_reset_outputs("midrst");
                    reset_hit = 1;
                    break;
                end
            end

            // Slave stimulus for this cycle.
            rdy = (n > stall) && ($urandom_range(99) < rdy_pct);
            if (rst_in_wr && wr_phase) rdy = 0;
            rd = {$urandom, $urandom};
            rv = 0;
            if (outst) begin
                if (n >= rsp_at) begin
                    rv = 1;
                    if (!cur_wr) rd = (reads_done < n_zero) ? 64'h0 : final_val;
                end
            end else begin
                // Stray responses outside a response wait must be ignored.
                rv = ($urandom_range(3) == 0);
            end
            pcr.htif_pcr_req_ready  = rdy;
            pcr.htif_pcr_resp_valid = rv;
            pcr.htif_pcr_resp_data  = rd;

            // Model step to the next cycle.
            xfer = exp_rv && rdy;
            acc  = exp_rr && rv;
            to_c = (maxc != 0) && (m_cyc > maxc) && !m_done;
            if (!m_done && m_cyc != '1) m_cyc = m_cyc + 1;
            if (acc && cur_wr) begin
                m_done = 1; outst = 0;
                if (latched == 64'd1) m_pass = 1;
                else begin
                    m_fail = 1;
                    m_code = latched >> 1;
                end
            end else if (to_c) begin
                m_done = 1; m_to = 1; outst = 0;
            end else if (xfer) begin
                outst  = 1;
                cur_wr = wr_phase;
                if (wr_phase) wr_sent = 1;
                rsp_at = n + 1 + $urandom_range(dmax, dmin);
            end else if (acc) begin
                outst = 0;
                reads_done++;
                if (rd == 0) next_req = n + PG;
                else begin
                    latched  = rd;
                    wr_phase = 1;
                    next_req = n + 1;
                end
            end

            @(negedge clk);
        end

        if (!reset_hit) chk("end_done", done, 1);
    endtask

    initial begin
        logic [63:0] fv;
        logic [63:0] mc;

        apply_reset();

        // Immediate pass: one zero read, then 1.
        run_scenario(1, 64'd1, 64'd0, 100, 0, 0, 0, 0, 500);
        chk("pass_final", pass, 1);
        chk("pass_code", fail_code, 0);

        // Fail code.
        apply_reset();
        run_scenario(0, 64'h2B, 64'd0, 100, 0, 0, 0, 0, 500);
        chk("fail_final", fail, 1);
        chk("fail_code_15", fail_code, 64'h15);

        // Backpressure: ready low for 5 request cycles, response 3 cycles late.
        apply_reset();
        run_scenario(0, 64'd1, 64'd0, 100, 5, 3, 3, 0, 500);

        // Timeout at max_cycles = 20, reads always zero.
        apply_reset();
        run_scenario(1000000, 64'd1, 64'd20, 100, 0, 0, 0, 0, 500);
        chk("to_flag", timeout, 1);
        chk("to_frozen_cnt", cycle_count, 64'd22);

        // Timeout disabled, long run of zero reads.
        apply_reset();
        run_scenario(112, 64'd1, 64'd0, 100, 0, 0, 0, 0, 4000);
        chk("notimeout_pass", pass, 1);

        // Mid-run reset during the clearing write, then a clean restart.
        apply_reset();
        run_scenario(1, 64'd1, 64'd0, 100, 0, 0, 0, 1, 500);
        apply_reset();
        run_scenario(1, 64'd1, 64'd0, 100, 0, 0, 0, 0, 500);

        // Randomized runs, including timeouts racing responses.
        for (int k = 0; k < 16; k++) begin
            fv = ($urandom_range(2) == 0) ? 64'd1 : {$urandom, $urandom};
            if (fv == 0) fv = 64'd3;
            mc = ($urandom_range(1) == 0) ? 64'd0 : 64'($urandom_range(80, 5));
            apply_reset();
            run_scenario($urandom_range(4), fv, mc, $urandom_range(100, 30),
                         $urandom_range(3), 0, $urandom_range(4), 0, 2000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
